// File: rtl/mdc_delay_commutator_if.sv
// rtl/mdc_delay_commutator_if.sv - sample-pair bus for the MDC delay-commutator stage
interface mdc_delay_commutator_if #(
  parameter int WIDTH = 9
);
  logic                    mode;
  logic                    in_valid;
  logic signed [WIDTH-1:0] inUI_re;
  logic signed [WIDTH-1:0] inUI_im;
  logic signed [WIDTH-1:0] inLI_re;
  logic signed [WIDTH-1:0] inLI_im;
  logic                    out_valid;
  logic signed [WIDTH-1:0] Up_out_re;
  logic signed [WIDTH-1:0] Up_out_im;
  logic signed [WIDTH-1:0] Low_out_re;
  logic signed [WIDTH-1:0] Low_out_im;
  logic                    sel_out;

  modport master (
    output mode, in_valid, inUI_re, inUI_im, inLI_re, inLI_im,
    input  out_valid, Up_out_re, Up_out_im, Low_out_re, Low_out_im, sel_out
  );

  modport slave (
    input  mode, in_valid, inUI_re, inUI_im, inLI_re, inLI_im,
    output out_valid, Up_out_re, Up_out_im, Low_out_re, Low_out_im, sel_out
  );
endinterface

// File: rtl/mdc_delay_commutator.sv
// rtl/mdc_delay_commutator.sv - MDC FFT delay-commutator stage with valid gating and frame-aligned bypass
module mdc_delay_commutator #(
  parameter int WIDTH = 9,
  parameter int DELAY = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mdc_delay_commutator_if.slave  bus
);
  localparam int CW = $clog2(2 * DELAY);
  localparam int PW = $clog2(DELAY + 1);

  logic [CW-1:0]           cnt;
  logic [PW-1:0]           prime_cnt;
  logic                    primed;
  logic                    mode_lat;
  logic                    mode_eff;
  logic                    sel;

  logic signed [WIDTH-1:0] ld_re [DELAY];
  logic signed [WIDTH-1:0] ld_im [DELAY];
  logic signed [WIDTH-1:0] ud_re [DELAY];
  logic signed [WIDTH-1:0] ud_im [DELAY];

  logic signed [WIDTH-1:0] top_re;
  logic signed [WIDTH-1:0] top_im;
  logic signed [WIDTH-1:0] bot_re;
  logic signed [WIDTH-1:0] bot_im;

  // Switch state is the MSB of the block counter: low half / high half of each 2*DELAY block.
  assign sel         = cnt[CW-1];
  assign bus.sel_out = sel;

  // Mode is only taken from the port at block start; elsewhere the latched copy rules.
  assign mode_eff = (cnt == '0) ? bus.mode : mode_lat;

  // 2x2 switch between the fresh upper sample and the delayed lower sample.
  always_comb begin
    top_re = bus.inUI_re;
    top_im = bus.inUI_im;
    bot_re = ld_re[DELAY-1];
    bot_im = ld_im[DELAY-1];
    if (sel) begin
      top_re = ld_re[DELAY-1];
      top_im = ld_im[DELAY-1];
      bot_re = bus.inUI_re;
      bot_im = bus.inUI_im;
    end
  end

  // Block counter, mode latch and priming; bypass drops priming so commutate restarts cleanly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      mode_lat  <= 1'b0;
      primed    <= 1'b0;
      prime_cnt <= '0;
    end else if (bus.in_valid) begin
      cnt      <= cnt + CW'(1);
      mode_lat <= mode_eff;
      if (mode_eff) begin
        primed    <= 1'b0;
        prime_cnt <= '0;
      end else if (!primed) begin
        prime_cnt <= prime_cnt + PW'(1);
        if (prime_cnt == PW'(DELAY - 1)) begin
          primed <= 1'b1;
        end
      end
    end
  end

  // Lower input and upper output delay lines; both advance on every accepted sample, even in bypass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        ld_re[i] <= '0;
        ld_im[i] <= '0;
        ud_re[i] <= '0;
        ud_im[i] <= '0;
      end
    end else if (bus.in_valid) begin
      for (int i = DELAY - 1; i > 0; i--) begin
        ld_re[i] <= ld_re[i-1];
        ld_im[i] <= ld_im[i-1];
        ud_re[i] <= ud_re[i-1];
        ud_im[i] <= ud_im[i-1];
      end
      ld_re[0] <= bus.inLI_re;
      ld_im[0] <= bus.inLI_im;
      ud_re[0] <= top_re;
      ud_im[0] <= top_im;
    end
  end

  // Output register: data holds on idle cycles, valid only follows accepted samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.Up_out_re  <= '0;
      bus.Up_out_im  <= '0;
      bus.Low_out_re <= '0;
      bus.Low_out_im <= '0;
    end else if (bus.in_valid) begin
      if (mode_eff) begin
        bus.out_valid  <= 1'b1;
        bus.Up_out_re  <= bus.inUI_re;
        bus.Up_out_im  <= bus.inUI_im;
        bus.Low_out_re <= bus.inLI_re;
        bus.Low_out_im <= bus.inLI_im;
      end else begin
        bus.out_valid  <= primed;
        bus.Up_out_re  <= ud_re[DELAY-1];
        bus.Up_out_im  <= ud_im[DELAY-1];
        bus.Low_out_re <= bot_re;
        bus.Low_out_im <= bot_im;
      end
    end else begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mdc_delay_commutator.sv
// tb/tb_mdc_delay_commutator.sv - directed table-driven bench for mdc_delay_commutator at DELAY 2, 4, 1, 16
module tb_mdc_delay_commutator;
  typedef struct {
    bit         m;
    logic [8:0] u;
    logic [8:0] l;
    bit         ev;
    bit         cd;
    logic [8:0] eu;
    logic [8:0] el;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic [8:0] ui_re, ui_im, li_re, li_im;

  logic [3:0]       ov;
  logic [3:0]       so;
  logic [3:0][8:0]  up_re, up_im, lo_re, lo_im;

  logic [8:0] a_re [64];
  logic [8:0] a_im [64];
  logic [8:0] b_re [64];
  logic [8:0] b_im [64];

  vec_t tab [8];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instance 0: DELAY 2, 1: DELAY 4, 2: DELAY 1, 3: DELAY 16; all share the stimulus.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 16;
    mdc_delay_commutator_if #(.WIDTH(9)) bus ();
    assign bus.mode     = mode;
    assign bus.in_valid = in_valid;
    assign bus.inUI_re  = ui_re;
    assign bus.inUI_im  = ui_im;
    assign bus.inLI_re  = li_re;
    assign bus.inLI_im  = li_im;
    mdc_delay_commutator #(.WIDTH(9), .DELAY(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign ov[g]    = bus.out_valid;
    assign so[g]    = bus.sel_out;
    assign up_re[g] = bus.Up_out_re;
    assign up_im[g] = bus.Up_out_im;
    assign lo_re[g] = bus.Low_out_re;
    assign lo_im[g] = bus.Low_out_im;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(bit m, int u, int l, bit ev, bit cd, int eu, int el);
    vec_t v;
    v.m  = m;
    v.u  = 9'(u);
    v.l  = 9'(l);
    v.ev = ev;
    v.cd = cd;
    v.eu = 9'(eu);
    v.el = 9'(el);
    return v;
  endfunction

  // Reference reordering: after accepting sample s (s >= d) of an aligned stream.
  function automatic logic [8:0] m_up(int s, int d, bit im);
    bit hi;
    hi = (s % (2 * d)) >= d;
    if (hi) return im ? a_im[s-d] : a_re[s-d];
    return im ? b_im[s-2*d] : b_re[s-2*d];
  endfunction

  function automatic logic [8:0] m_low(int s, int d, bit im);
    bit hi;
    hi = (s % (2 * d)) >= d;
    if (hi) return im ? a_im[s] : a_re[s];
    return im ? b_im[s-d] : b_re[s-d];
  endfunction

  task automatic chk_pair(input string nm, input int g, input int s, input int d);
    chk({nm, "_up_re"},  up_re[g], m_up(s, d, 1'b0));
    chk({nm, "_up_im"},  up_im[g], m_up(s, d, 1'b1));
    chk({nm, "_low_re"}, lo_re[g], m_low(s, d, 1'b0));
    chk({nm, "_low_im"}, lo_im[g], m_low(s, d, 1'b1));
  endtask

  task automatic put(input bit m, input logic [8:0] u, input logic [8:0] l);
    in_valid = 1'b1;
    mode     = m;
    ui_re    = u;
    ui_im    = -u;
    li_re    = l;
    li_im    = -l;
    tick();
  endtask

  task automatic push(input int s, input bit m);
    in_valid = 1'b1;
    mode     = m;
    ui_re    = a_re[s];
    ui_im    = a_im[s];
    li_re    = b_re[s];
    li_im    = b_im[s];
    tick();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 64; k++) begin
      a_re[k] = 9'(k);
      a_im[k] = -a_re[k];
      b_re[k] = 9'(16 + k);
      b_im[k] = -b_re[k];
    end
  endtask

  initial begin
    int k;
    int nv;
    logic [8:0] pu, pl;
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0;
    ui_re = '0; ui_im = '0; li_re = '0; li_im = '0;

    // Reset state
    do_reset();
    chk1("rst_valid", ov[0], 1'b0);
    chk1("rst_sel", so[0], 1'b0);
    chk("rst_up_re", up_re[0], 9'd0);
    chk("rst_low_re", lo_re[0], 9'd0);

    // Test 1: continuous commutate stream, DELAY 2
    tab[0] = mkv(1'b0, 0, 16, 1'b0, 1'b0, 0, 0);
    tab[1] = mkv(1'b0, 1, 17, 1'b0, 1'b0, 0, 0);
    tab[2] = mkv(1'b0, 2, 18, 1'b1, 1'b1, 0, 2);
    tab[3] = mkv(1'b0, 3, 19, 1'b1, 1'b1, 1, 3);
    tab[4] = mkv(1'b0, 4, 20, 1'b1, 1'b1, 16, 18);
    tab[5] = mkv(1'b0, 5, 21, 1'b1, 1'b1, 17, 19);
    tab[6] = mkv(1'b0, 6, 22, 1'b1, 1'b1, 4, 6);
    tab[7] = mkv(1'b0, 7, 23, 1'b1, 1'b1, 5, 7);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      put(tab[i].m, tab[i].u, tab[i].l);
      chk1($sformatf("t1_valid_%0d", i), ov[0], tab[i].ev);
      if (tab[i].cd) begin
        chk($sformatf("t1_up_re_%0d", i), up_re[0], tab[i].eu);
        chk($sformatf("t1_up_im_%0d", i), up_im[0], -tab[i].eu);
        chk($sformatf("t1_low_re_%0d", i), lo_re[0], tab[i].el);
        chk($sformatf("t1_low_im_%0d", i), lo_im[0], -tab[i].el);
      end
    end

    // Test 2: same stream with a gap every third cycle, DELAY 2
    fill_ramp();
    do_reset();
    k = 0; nv = 0; pu = '0; pl = '0;
    for (int c = 0; k < 8 && c < 40; c++) begin
      if (c % 3 == 2) begin
        in_valid = 1'b0;
        tick();
        chk1($sformatf("t2_gap_valid_%0d", c), ov[0], 1'b0);
        chk($sformatf("t2_gap_hold_up_%0d", c), up_re[0], pu);
        chk($sformatf("t2_gap_hold_low_%0d", c), lo_re[0], pl);
      end else begin
        push(k, 1'b0);
        chk1($sformatf("t2_valid_%0d", k), ov[0], k >= 2);
        if (ov[0]) begin
          nv++;
          chk_pair($sformatf("t2_s%0d", k), 0, k, 2);
        end
        k++;
      end
      pu = up_re[0];
      pl = lo_re[0];
    end
    chk("t2_valid_count", 9'(nv), 9'd6);

    // Test 3: reset mid-frame, DELAY 4
    do_reset();
    for (int s = 0; s < 5; s++) put(1'b0, 9'(s + 10), 9'(s + 20));
    chk1("t3_pre_reset_valid", ov[1], 1'b1);
    chk("t3_pre_reset_up", up_re[1], 9'd10);
    do_reset();
    chk1("t3_rst_valid", ov[1], 1'b0);
    chk1("t3_rst_sel", so[1], 1'b0);
    chk("t3_rst_up_re", up_re[1], 9'd0);
    chk("t3_rst_up_im", up_im[1], 9'd0);
    chk("t3_rst_low_re", lo_re[1], 9'd0);
    chk("t3_rst_low_im", lo_im[1], 9'd0);
    fill_ramp();
    for (int s = 0; s < 9; s++) begin
      push(s, 1'b0);
      chk1($sformatf("t3_valid_%0d", s), ov[1], s >= 4);
      if (ov[1]) chk_pair($sformatf("t3_s%0d", s), 1, s, 4);
    end

    // Test 4: bypass, mid-block mode toggles ignored, re-prime on return, DELAY 2
    tab[0] = mkv(1'b1, 7, -3, 1'b1, 1'b1, 7, -3);
    tab[1] = mkv(1'b0, 5, -2, 1'b1, 1'b1, 5, -2);
    tab[2] = mkv(1'b1, 9, -4, 1'b1, 1'b1, 9, -4);
    tab[3] = mkv(1'b0, 1, -1, 1'b1, 1'b1, 1, -1);
    tab[4] = mkv(1'b0, 40, 50, 1'b0, 1'b0, 0, 0);
    tab[5] = mkv(1'b0, 41, 51, 1'b0, 1'b0, 0, 0);
    tab[6] = mkv(1'b0, 42, 52, 1'b1, 1'b1, 40, 42);
    tab[7] = mkv(1'b1, 43, 53, 1'b1, 1'b1, 41, 43);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      put(tab[i].m, tab[i].u, tab[i].l);
      chk1($sformatf("t4_valid_%0d", i), ov[0], tab[i].ev);
      if (tab[i].cd) begin
        chk($sformatf("t4_up_re_%0d", i), up_re[0], tab[i].eu);
        chk($sformatf("t4_up_im_%0d", i), up_im[0], -tab[i].eu);
        chk($sformatf("t4_low_re_%0d", i), lo_re[0], tab[i].el);
        chk($sformatf("t4_low_im_%0d", i), lo_im[0], -tab[i].el);
      end
    end

    // Test 5: DELAY 1 with full-scale values
    for (int s = 0; s < 64; s++) begin
      a_re[s] = (s % 2 == 0) ? 9'h100 : 9'h0FF;
      a_im[s] = ~a_re[s];
      b_re[s] = 9'(s);
      b_im[s] = ~b_re[s];
    end
    do_reset();
    for (int s = 0; s < 8; s++) begin
      push(s, 1'b0);
      chk1($sformatf("t5_valid_%0d", s), ov[2], s >= 1);
      chk1($sformatf("t5_sel_%0d", s), so[2], (s % 2) == 0);
      if (ov[2]) chk_pair($sformatf("t5_s%0d", s), 2, s, 1);
    end

    // Test 6: DELAY 16, 32 pairs then 16 zero flush samples
    for (int s = 0; s < 64; s++) begin
      a_re[s] = (s < 32) ? 9'(s * 7 + 3)   : 9'd0;
      a_im[s] = (s < 32) ? 9'(s * 11 - 100) : 9'd0;
      b_re[s] = (s < 32) ? 9'(200 - s * 13) : 9'd0;
      b_im[s] = (s < 32) ? 9'(s * 3 - 255)  : 9'd0;
    end
    do_reset();
    nv = 0;
    for (int s = 0; s < 48; s++) begin
      push(s, 1'b0);
      chk1($sformatf("t6_valid_%0d", s), ov[3], s >= 16);
      if (ov[3]) begin
        nv++;
        chk_pair($sformatf("t6_s%0d", s), 3, s, 16);
      end
    end
    chk("t6_valid_count", 9'(nv), 9'd32);

    in_valid = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mdc_delay_commutator.md
Name: mdc_delay_commutator

Overview:
- Parametrised delay-commutator stage for the MDC FFT pipeline: delay buffer on the lower input, 2x2 switch, delay buffer on the upper output.
- Reorders the two complex lanes between butterfly stages so the next stage receives samples DELAY apart in its pair.
- Replaces the fixed-state combinational commutators with one sequential block, instantiated per stage with DELAY = 16, 8, 4, 2, 1.
- Has sample-valid gating and a frame-aligned bypass mode.

Parameters:
- WIDTH, 9, bit width of each signed real/imag component.
- DELAY, 8, delay depth in accepted samples and half-period of the switch; power of two, >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- mode  input  1  0: commutate, 1: bypass. Latched at frame start only.
- in_valid  input  1  qualifies the input pair; all internal state advances only when this is high.
- inUI_re, inUI_im  input  WIDTH each  upper-lane complex sample, signed.
- inLI_re, inLI_im  input  WIDTH each  lower-lane complex sample, signed.
- out_valid  output  1  qualifies the output pair.
- Up_out_re, Up_out_im  output  WIDTH each  upper-lane output, signed, registered.
- Low_out_re, Low_out_im  output  WIDTH each  lower-lane output, signed, registered.
- sel_out  output  1  current switch state, for debug and verification.

Behaviour:
- Reset: when rst_n = 0 at a clock edge, the following are cleared.
  - All outputs = 0; out_valid = 0; sel_out = 0.
  - Sample counter cnt = 0.
  - Both delay lines cleared to 0.
  - primed = 0; latched mode = 0.
  - Reset mid-frame discards all buffered data. No output is produced for pre-reset samples.
- cnt: log2(2*DELAY) bits. Increments on every accepted sample (in_valid = 1) and wraps 2*DELAY-1 -> 0.
- sel = (cnt >= DELAY), i.e. the MSB of cnt. sel_out reflects sel for the current sample.
- Mode latch:
  - When in_valid = 1 and cnt = 0, mode is sampled and applies to that sample and the rest of the 2*DELAY block.
  - mode changes at any other time are ignored until the next wrap.
- Lower delay line: DELAY-deep shift register on inLI (re and im), shifting only on accepted samples. Ld = inLI from DELAY accepted samples earlier.
- Switch, commutate mode:
  - sel = 0: top_sw = inUI, bot_sw = Ld.
  - sel = 1: top_sw = Ld, bot_sw = inUI.
- Upper output delay line: DELAY-deep shift register on top_sw, shifting on accepted samples. Its output is Ud.
- Output register, loaded on each accepted sample:
  - Up_out <= Ud; Low_out <= bot_sw.
  - out_valid <= primed_next, where primed_next is 1 once DELAY samples have been accepted in commutate mode. primed is sticky.
  - On cycles without in_valid: out_valid <= 0 and data outputs hold their value.
- Latency: out_valid first rises 1 clock after accepting sample index DELAY (0-based). Steady-state latency is DELAY accepted samples plus 1 clock.
- Resulting pairs: (a_k, a_{k+DELAY}) for the first half of each 2*DELAY block, then (b_k, b_{k+DELAY}).
- Bypass mode:
  - Up_out <= inUI and Low_out <= inLI, 1-clock latency; out_valid <= in_valid.
  - Delay lines keep shifting.
  - primed is cleared, so returning to commutate mode re-primes: out_valid stays low for the first DELAY accepted samples.
- No arithmetic is performed. Widths are preserved exactly and there is no sign extension or truncation.
- Drain: the last DELAY samples of a stream leave only when further samples are pushed. Upstream flushes with zero-valued valid samples.
- DELAY = 1: each delay line is a single register, and sel toggles on every accepted sample.

Test Plan:
1. Commutate, continuous stream (DELAY = 2, WIDTH = 9, mode = 0):
   - Stimulus: in_valid = 1 from cycle 0; inUI_re = k, inLI_re = 16+k, im = -re.
   - Required: out_valid first high at cycle 3. (Up_out_re, Low_out_re) = (0,2), (1,3), (16,18), (17,19), (4,6), (5,7). im = -re throughout.
2. Stalls (DELAY = 2):
   - Stimulus: the same stream as test 1 with in_valid low on every third cycle.
   - Required: an identical out_valid-qualified sequence. out_valid = 0 in the cycle after each gap, and outputs hold during gaps.
3. Reset mid-frame (DELAY = 4):
   - Stimulus: assert rst_n = 0 for 1 cycle after 5 accepted samples, then restart the stream at k = 0.
   - Required: outputs = 0, out_valid = 0, sel_out = 0 the cycle after reset. The first valid pair after the restart is (0,4). No pre-reset data appears.
4. Bypass and mode latch (DELAY = 2):
   - Stimulus: mode = 1 at cnt = 0; inUI = 7, inLI = -3. Toggle mode at cnt = 1.
   - Required: outputs (7,-3) 1 clock later with out_valid = 1. The toggle has no effect until the next cnt = 0.
   - Stimulus: switch back to mode = 0.
   - Required: out_valid low for 2 accepted samples.
5. DELAY = 1 with extreme values:
   - Stimulus: inUI_re alternating -256 and 255, inLI_re = 0, 1, ...
   - Required: pairs (a0,a1), (b0,b1), ... with exact bit patterns (-256 stays 9'h100). sel_out toggles every accepted sample.
6. DELAY = 16 full frame:
   - Stimulus: 32 pairs, followed by 16 zero flush samples.
   - Required: 32 output pairs matching a reference model of the reordering above. Total out_valid count = 32 before the flush tail.
